// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the CPU memory-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch and
//               load/store; LS has priority, bounded by an LS streak limit.
//               Optional BUSY timeout enabled by defining ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LS_MAX  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [BE_W-1:0]     ls_be,
    input  logic [DATA_W-1:0]   ls_wdata,
    output logic                ls_ack,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [BE_W-1:0]     mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                err
);

    localparam logic [3:0] c_ls_max = 4'(LS_MAX);

    if (LS_MAX < 1 || LS_MAX > 15) begin : g_bad_ls_max
        $error("mem_port_arbiter: LS_MAX must be in 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT must be in 1..255");
    end

    arb_state_t          state_q, state_d;
    arb_owner_t          owner_q, owner_d;
    logic [3:0]          ls_streak_q, ls_streak_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
    logic                if_ack_q, if_ack_d;
    logic                ls_ack_q, ls_ack_d;

    logic                w_grant_ls;
    logic                w_timeout;
    logic                w_finish;
    logic [DATA_W-1:0]   w_fin_data;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] c_timeout = 8'(TIMEOUT);
    logic [7:0]          to_cnt_q, to_cnt_d;
    logic                to_first_q, to_first_d;
    logic                err_q, err_d;

    // The entry cycle only clears the counter; counting starts on the next BUSY cycle.
    assign w_timeout = (state_q == BUSY) && !to_first_q && (to_cnt_q == c_timeout);
    assign err       = err_q;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    assign w_grant_ls = ls_req && (!if_req || (ls_streak_q != c_ls_max));
    assign w_finish   = mem_ack || w_timeout;
    assign w_fin_data = (mem_ack && !mem_we_q) ? mem_rdata : '0;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ls_streak_d = ls_streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_ack_d    = 1'b0;
        ls_ack_d    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        to_first_d  = to_first_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (w_grant_ls) begin
                    owner_d     = OWN_LS;
                    mem_we_d    = ls_we;
                    mem_addr_d  = ls_addr;
                    mem_be_d    = ls_be;
                    mem_wdata_d = ls_wdata;
                    if (!if_req)
                        ls_streak_d = 4'd0;
                    else if (ls_streak_q != 4'hF)
                        ls_streak_d = ls_streak_q + 4'd1;
                end else if (if_req) begin
                    owner_d     = OWN_IF;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_be_d    = {BE_W{1'b1}};
                    mem_wdata_d = '0;
                    ls_streak_d = 4'd0;
                end
                if (w_grant_ls || if_req) begin
                    mem_req_d = 1'b1;
                    state_d   = BUSY;
`ifdef ARB_TIMEOUT_EN
                    to_cnt_d   = 8'd0;
                    to_first_d = 1'b1;
`endif
                end
            end
            BUSY: begin
                if (w_finish) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    if (owner_q == OWN_IF) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = w_fin_data;
                    end else begin
                        ls_ack_d   = 1'b1;
                        ls_rdata_d = w_fin_data;
                    end
`ifdef ARB_TIMEOUT_EN
                    err_d = !mem_ack;
                end else if (to_first_q) begin
                    to_cnt_d   = 8'd0;
                    to_first_d = 1'b0;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            ls_streak_q <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            ls_ack_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            to_cnt_q    <= 8'd0;
            to_first_q  <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ls_streak_q <= ls_streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            if_ack_q    <= if_ack_d;
            ls_ack_q    <= ls_ack_d;
`ifdef ARB_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            to_first_q  <= to_first_d;
            err_q       <= err_d;
`endif
        end
    end

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign ls_ack    = ls_ack_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire
